// File: rtl/uart_rs232_tx_ser.sv
// uart_rs232_tx_ser: RS-232 transmit serialiser, 1 start bit, 6/7/8 data bits LSB first, 1 stop bit, no parity.
// Latency: write sampled at edge k -> start bit on Tx after edge k+1; every bit lasts 16 Ticks.
// Backpressure: TxReady is low while the one-entry holding register is full; TxStart is then ignored.
module uart_rs232_tx_ser (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Tick,
   input  logic       TxEn,
   input  logic       TxStart,
   input  logic [7:0] TxData,
   input  logic [3:0] NBits,
   output logic       Tx,
   output logic       TxReady,
   output logic       TxBusy,
   output logic       TxDone
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t     state, state_nxt;

   // Holding register: lets the host queue the next character while a frame shifts.
   logic [7:0] hold, hold_nxt;
   logic       hold_full, hold_full_nxt;

   // Frame datapath: shifter, Tick counter within a bit, data-bit counter, latched length.
   logic [7:0] sh, sh_nxt;
   logic [3:0] tcnt, tcnt_nxt;
   logic [3:0] bcnt, bcnt_nxt;
   logic [3:0] nb, nb_nxt;

   // Registered line and done pulse.
   logic       tx_q, tx_nxt;
   logic       done_q, done_nxt;

   logic       bit_end;
   logic       wr_acc;
   logic       load;
   logic [3:0] nb_sane;

   // Only 6 and 7 are short formats; any other code falls back to 8 data bits.
   assign nb_sane = (NBits == 4'd6 || NBits == 4'd7) ? NBits : 4'd8;

   // The 16th Tick of the current bit closes that bit.
   assign bit_end = Tick && (tcnt == 4'd15);

   assign wr_acc  = TxStart && !hold_full;

   assign TxReady = !hold_full;
   assign TxBusy  = (state != IDLE);
   assign Tx      = tx_q;
   assign TxDone  = done_q;

   // Next-state, datapath and line value for the frame sequencer.
   always_comb begin
      state_nxt     = state;
      hold_nxt      = hold;
      hold_full_nxt = hold_full;
      sh_nxt        = sh;
      tcnt_nxt      = tcnt;
      bcnt_nxt      = bcnt;
      nb_nxt        = nb;
      tx_nxt        = tx_q;
      done_nxt      = 1'b0;
      load          = 1'b0;

      case (state)
         IDLE: begin
            // Ticks are ignored here; the counter restarts at every load.
            tx_nxt = 1'b1;
            if (hold_full && TxEn) begin
               load = 1'b1;
            end
         end

         START: begin
            if (Tick) begin
               tcnt_nxt = tcnt + 4'd1;
            end
            if (bit_end) begin
               tx_nxt    = sh[0];
               sh_nxt    = sh >> 1;
               bcnt_nxt  = 4'd1;
               state_nxt = DATA;
            end
         end

         DATA: begin
            if (Tick) begin
               tcnt_nxt = tcnt + 4'd1;
            end
            if (bit_end) begin
               if (bcnt < nb) begin
                  tx_nxt   = sh[0];
                  sh_nxt   = sh >> 1;
                  bcnt_nxt = bcnt + 4'd1;
               end else begin
                  tx_nxt    = 1'b1;
                  state_nxt = STOP;
               end
            end
         end

         STOP: begin
            if (Tick) begin
               tcnt_nxt = tcnt + 4'd1;
            end
            if (bit_end) begin
               done_nxt = 1'b1;
               // A queued character starts right after the stop bit, no idle bit between.
               if (hold_full && TxEn) begin
                  load = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase

      // Frame load: the Tick sampled on this edge is deliberately not counted.
      if (load) begin
         sh_nxt        = hold;
         nb_nxt        = nb_sane;
         hold_full_nxt = 1'b0;
         tcnt_nxt      = 4'd0;
         tx_nxt        = 1'b0;
         state_nxt     = START;
      end

      // Host write comes after the load so a coincident write refills the register.
      if (wr_acc) begin
         hold_nxt      = TxData;
         hold_full_nxt = 1'b1;
      end
   end

   // State and datapath registers; reset aborts any frame and drops the queued character.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= IDLE;
         hold      <= 8'd0;
         hold_full <= 1'b0;
         sh        <= 8'd0;
         tcnt      <= 4'd0;
         bcnt      <= 4'd0;
         nb        <= 4'd0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold      <= hold_nxt;
         hold_full <= hold_full_nxt;
         sh        <= sh_nxt;
         tcnt      <= tcnt_nxt;
         bcnt      <= bcnt_nxt;
         nb        <= nb_nxt;
         tx_q      <= tx_nxt;
         done_q    <= done_nxt;
      end
   end

endmodule

// File: tb/tb_uart_rs232_tx_ser.sv
// tb_uart_rs232_tx_ser: randomized and directed stimulus for the RS-232 transmit serialiser.
// Expected frames are queued at write time; a monitor decodes Tx by counting Ticks and compares.
// Writes are issued only when the bench's own bookkeeping says the holding register is empty.
module tb_uart_rs232_tx_ser;

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic       Tick;
   logic       TxEn;
   logic       TxStart;
   logic [7:0] TxData;
   logic [3:0] NBits;
   logic       Tx;
   logic       TxReady;
   logic       TxBusy;
   logic       TxDone;

   typedef struct {
      logic [7:0] d;
      int         n;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       cur;
   logic [9:0] cur_bits;
   logic [9:0] obs;
   int         n_cmp = 0;
   int         n_fail = 0;
   int         wr_cnt = 0;
   int         start_cnt = 0;
   int         frames_done = 0;
   int         b2b_cnt = 0;
   int         stray = 0;
   int         ferr = 0;
   int         t = 0;
   bit         in_frame = 1'b0;

   uart_rs232_tx_ser dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Tick    (Tick),
      .TxEn    (TxEn),
      .TxStart (TxStart),
      .TxData  (TxData),
      .NBits   (NBits),
      .Tx      (Tx),
      .TxReady (TxReady),
      .TxBusy  (TxBusy),
      .TxDone  (TxDone)
   );

   always #5 Clk = ~Clk;

   // Data bits per frame implied by an NBits code.
   function automatic int frame_bits(input logic [3:0] code);
      return (code == 4'd6 || code == 4'd7) ? int'(code) : 8;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic sync();
      @(posedge Clk);
      #1;
   endtask

   task automatic tick_gen();
      forever begin
         @(posedge Clk);
         #1;
         Tick = ($urandom_range(0, 3) == 0);
      end
   endtask

   // Frame seen on the line: take the oldest expected character and build its bit sequence.
   task automatic start_frame();
      chk("frame_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
      end else begin
         cur.d = 8'h00;
         cur.n = 8;
      end
      cur_bits = '1;
      cur_bits[0] = 1'b0;
      for (int i = 0; i < cur.n; i++) begin
         cur_bits[4'(i + 1)] = cur.d[i];
      end
      obs       = '0;
      ferr      = 0;
      t         = 0;
      in_frame  = 1'b1;
      start_cnt = start_cnt + 1;
   endtask

   task automatic end_frame();
      bit b2b_exp;
      b2b_exp = (wr_cnt != start_cnt) && TxEn;
      chk("done_pulse", int'(TxDone), 1);
      chk($sformatf("frame_%02h_n%0d_line_%b", cur.d, cur.n, obs), ferr, 0);
      chk("end_state_busy_tx", int'({TxBusy, Tx}), b2b_exp ? 2 : 1);
      frames_done = frames_done + 1;
      in_frame    = 1'b0;
      if (b2b_exp && Tx === 1'b0) begin
         b2b_cnt = b2b_cnt + 1;
         start_frame();
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge Clk);
         if (!Rst_n) begin
            in_frame  = 1'b0;
            exp_q.delete();
            start_cnt = wr_cnt;
         end else begin
            if (!in_frame) begin
               if (TxDone !== 1'b0) stray++;
               if (Tx === 1'b0) start_frame();
            end else if (t == (cur.n + 2) * 16) begin
               end_frame();
            end
            if (in_frame) begin
               if (Tx !== cur_bits[4'(t / 16)] || TxBusy !== 1'b1 || (t != 0 && TxDone !== 1'b0)) ferr++;
               if (t % 16 == 8) obs[4'(t / 16)] = Tx;
               if (Tick) t++;
            end
         end
      end
   endtask

   task automatic do_write(input logic [7:0] d);
      int   k;
      exp_t e;
      k = 0;
      while (wr_cnt != start_cnt && k < 20000) begin
         sync();
         k++;
      end
      if (k >= 20000) chk("write_wait_timeout", 1, 0);
      chk("wr_ready", int'(TxReady), 1);
      TxStart = 1'b1;
      TxData  = d;
      e.d = d;
      e.n = frame_bits(NBits);
      exp_q.push_back(e);
      wr_cnt = wr_cnt + 1;
      sync();
      TxStart = 1'b0;
      TxData  = 8'($urandom);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge Clk);
      while ((in_frame || wr_cnt != start_cnt) && k < 20000) begin
         @(negedge Clk);
         k++;
      end
      if (k >= 20000) chk("wait_idle_timeout", 1, 0);
   endtask

   task automatic wait_t(input int x);
      int k;
      k = 0;
      @(negedge Clk);
      while (!(in_frame && t >= x) && k < 20000) begin
         @(negedge Clk);
         k++;
      end
      if (k >= 20000) chk("wait_bit_timeout", 1, 0);
   endtask

   task automatic idle_ticks(input int n);
      int cnt, err, k;
      cnt = 0;
      err = 0;
      k   = 0;
      while (cnt < n && k < n * 40) begin
         @(negedge Clk);
         k++;
         if (Tx !== 1'b1) err++;
         if (Tick) cnt++;
      end
      if (cnt < n) chk("idle_tick_timeout", 1, 0);
      chk("idle_tx_high", err, 0);
   endtask

   initial begin
      int fd0, b0;
      Rst_n   = 1'b0;
      Tick    = 1'b0;
      TxEn    = 1'b1;
      TxStart = 1'b0;
      TxData  = 8'h00;
      NBits   = 4'd8;
      fork
         tick_gen();
         monitor();
      join_none

      // Reset values, then a long idle stretch with no writes.
      repeat (3) @(negedge Clk);
      chk("rst_tx", int'(Tx), 1);
      chk("rst_ready", int'(TxReady), 1);
      chk("rst_busy", int'(TxBusy), 0);
      chk("rst_done", int'(TxDone), 0);
      sync();
      Rst_n = 1'b1;
      idle_ticks(1000);

      // 8-bit frame with write-to-line latency.
      sync();
      do_write(8'hA5);
      @(negedge Clk);
      chk("lat_ready_low", int'(TxReady), 0);
      chk("lat_busy_low", int'(TxBusy), 0);
      chk("lat_tx_high", int'(Tx), 1);
      @(negedge Clk);
      chk("lat_tx_start", int'(Tx), 0);
      chk("lat_busy_high", int'(TxBusy), 1);
      chk("lat_ready_back", int'(TxReady), 1);
      wait_idle();

      // Short formats and an out-of-range code.
      sync(); NBits = 4'd7; do_write(8'hC3); wait_idle();
      sync(); NBits = 4'd6; do_write(8'h3F); wait_idle();
      sync(); NBits = 4'd9; do_write(8'h96); wait_idle();

      // Back-to-back frames; a third write while full must be dropped.
      sync();
      NBits = 4'd8;
      fd0 = frames_done;
      b0  = b2b_cnt;
      do_write(8'h55);
      do_write(8'h0F);
      TxStart = 1'b1;
      TxData  = 8'hEE;
      @(negedge Clk);
      chk("third_write_ready", int'(TxReady), 0);
      sync();
      TxStart = 1'b0;
      wait_idle();
      chk("b2b_count", b2b_cnt - b0, 1);
      chk("b2b_done_count", frames_done - fd0, 2);

      // TxEn gates frame start only.
      sync();
      TxEn = 1'b0;
      do_write(8'h81);
      repeat (40) @(negedge Clk);
      chk("gate_tx", int'(Tx), 1);
      chk("gate_ready", int'(TxReady), 0);
      chk("gate_busy", int'(TxBusy), 0);
      sync();
      TxEn = 1'b1;
      @(negedge Clk);
      chk("gate_pre_start", int'(Tx), 1);
      @(negedge Clk);
      chk("gate_start", int'(Tx), 0);
      wait_t(40);
      sync();
      TxEn = 1'b0;
      wait_idle();
      sync();
      TxEn = 1'b1;

      // NBits change mid-frame only affects the next frame.
      sync();
      NBits = 4'd8;
      do_write(8'hB4);
      wait_t(68);
      sync();
      NBits = 4'd6;
      do_write(8'h2D);
      wait_idle();

      // Reset mid-frame with a character queued.
      sync();
      NBits = 4'd8;
      do_write(8'h3C);
      do_write(8'hC7);
      wait_t(50);
      sync();
      Rst_n = 1'b0;
      @(negedge Clk);
      chk("arst_tx", int'(Tx), 1);
      chk("arst_ready", int'(TxReady), 1);
      chk("arst_busy", int'(TxBusy), 0);
      chk("arst_done", int'(TxDone), 0);
      repeat (2) sync();
      Rst_n = 1'b1;
      idle_ticks(300);

      // Randomized characters and formats, mixing queued and isolated frames.
      sync();
      for (int i = 0; i < 14; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            wait_idle();
            sync();
            NBits = 4'($urandom_range(0, 15));
         end
         do_write(8'($urandom));
      end
      wait_idle();
      chk("queue_empty", exp_q.size(), 0);
      chk("stray_done", stray, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rs232_tx_ser.md
# uart_rs232_tx_ser

Transmit half of the RS-232 UART link. Serialises one 6-, 7- or 8-bit character per frame onto `Tx`: one start bit (0), data LSB first, one stop bit (1), no parity. Bit timing comes from the shared 16x-oversampling `Tick` from the baud generator, so every bit lasts exactly 16 Ticks. A one-entry holding register lets the host queue the next character while the current frame is shifting, which gives back-to-back frames with no idle gap.

## Interface
- No parameters. Frame format is set at run time by `NBits`.
- Clk  input  1  system clock; all state updates on posedge.
- Rst_n  input  1  asynchronous, active-low reset.
- Tick  input  1  single-Clk-cycle pulse at 16x baud, synchronous to Clk; used only as a clock enable.
- TxEn  input  1  transmit enable; gates the start of new frames only.
- TxStart  input  1  write strobe; `TxData` is captured when `TxStart=1` and `TxReady=1`.
- TxData  input  8  character; bits [NBits-1:0] are sent.
- NBits  input  4  data bits per frame: 6, 7 or 8. Any other value is treated as 8.
- Tx  output  1  serial line, registered; idle high.
- TxReady  output  1  holding register empty; a write is accepted this cycle.
- TxBusy  output  1  a frame is in progress (state ≠ IDLE).
- TxDone  output  1  one-Clk pulse at the end of each stop bit.

## Operation
- Storage:
  - holding register `hold[7:0]` with flag `hold_full`;
  - shifter `sh[7:0]`;
  - Tick counter `tcnt[3:0]`;
  - bit counter `bcnt[3:0]`;
  - latched frame length `nb[3:0]`.
- Write: when `TxStart & TxReady`, `hold <= TxData` and `hold_full <= 1`. `TxStart` while `TxReady=0` is ignored and the held data is unchanged. `TxReady = !hold_full`, driven combinationally from the flag.
- States:
  - IDLE:
    - `Tx=1`.
    - If `hold_full & TxEn`: `sh <= hold`, `nb <=` sanitised `NBits`, `hold_full <= 0`, `tcnt <= 0`, `Tx <= 0`, go to START.
  - START:
    - Count Ticks.
    - On the 16th Tick (`tcnt==15 & Tick`): `Tx <= sh[0]`, `sh <= sh>>1`, `bcnt <= 1`, `tcnt <= 0`, go to DATA.
  - DATA:
    - On the 16th Tick, if `bcnt < nb`: `Tx <= sh[0]`, shift, `bcnt <= bcnt+1`.
    - On the 16th Tick, otherwise: `Tx <= 1`, go to STOP.
  - STOP:
    - On the 16th Tick, pulse `TxDone`.
    - If `hold_full & TxEn`: load as in IDLE (`Tx <= 0`) and go straight to START, with no idle bit.
    - Otherwise go to IDLE.
- `tcnt` increments only on Tick and wraps 15→0 at every bit boundary. A Tick sampled on the same edge a frame is loaded is not counted.
- `NBits` is latched at frame load. Changes mid-frame affect only later frames.
- `TxEn` deasserted mid-frame: the current frame completes normally. Queued data is held until `TxEn` returns.
- A write and a load on the same edge: the load takes the old `hold` and the write refills it, so `hold_full` stays 1.
- Unknown state: recover to IDLE with `Tx=1`.

## Timing
- Reset values:
  - `Tx=1`, `TxReady=1`, `TxBusy=0`, `TxDone=0`;
  - state IDLE, `hold_full=0`;
  - counters and registers 0.
- Reset mid-frame aborts the frame immediately: `Tx` returns to 1 and the queued character is discarded.
- Latency: `TxStart` sampled at edge k (IDLE, `TxEn=1`, empty) gives `hold_full=1` after k, and `Tx=0` and `TxBusy=1` after edge k+1.
- Each bit spans exactly 16 Ticks. A frame lasts `(NBits+2)*16` Ticks: 160, 144 or 128.
- `TxDone` is high for the single Clk cycle after the edge that samples the 16th stop-bit Tick. `TxBusy` falls on that same edge unless a back-to-back load occurs.
- `TxReady` rises the cycle after a load, so the next write is possible during the start bit of the current frame.
- Ticks arriving while in IDLE have no effect.

## Test plan
- Reset and idle: assert `Rst_n=0` mid-frame → next sampled cycle shows `Tx=1`, `TxReady=1`, `TxBusy=0`, `TxDone=0`. With no writes, `Tx` stays 1 for 1000 Ticks.
- 8-bit frame: `NBits=8`, write 0xA5 → `Tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 Ticks. One `TxDone` pulse after 160 Ticks.
- Short formats:
  - `NBits=7`, 0xC3 → 0,1,1,0,0,0,0,1,1, 144 Ticks.
  - `NBits=6`, 0x3F → 0,1,1,1,1,1,1,1, 128 Ticks.
  - `NBits=9` behaves as 8.
- Back-to-back: write 0x55, then write 0x0F during its start bit → second start bit directly follows the first stop bit, with no idle Ticks. A third write before the second load is ignored (`TxReady=0`). Two `TxDone` pulses.
- `TxEn` gating: `TxEn=0`, write 0x81 → `Tx` stays 1 and `TxReady=0`. Raise `TxEn` → frame for 0x81 starts one edge later. Drop `TxEn` mid-frame → frame completes.
- `NBits` change mid-frame: start an 8-bit frame, switch `NBits` to 6 at bit 3 → the frame still sends 8 data bits, and the next frame sends 6.
